rf_access_sequencer: RTL and testbench
======================================

// Module: rf_access_sequencer
// PURPOSE
//  Initiator side of the 32x32 dual-read register file: accepts operand-fetch /
//  writeback requests over a valid/ready handshake and sequences READ/WRITE
//  strobes, addresses and data onto the register-file port.
//  Only READ or only WRITE is asserted in any cycle.
//  Returns captured operands on a held response channel.
//  Sits between the control unit and the register file.
// PARAMETERS
//  DATA_WIDTH  32  register/data width
//  ADDR_WIDTH  5   register address width (2**ADDR_WIDTH registers)
// PORTS
//  CLK        in   1           clock, all logic +ve edge
//  RST        in   1           synchronous reset, active-high
//  req_valid  in   1           request present
//  req_ready  out  1           request accepted when valid&ready
//  req_rd     in   1           fetch operands from rs1/rs2
//  req_wr     in   1           write req_wdata to rd
//  req_rs1    in   ADDR_WIDTH  read address 1
//  req_rs2    in   ADDR_WIDTH  read address 2
//  req_rd_a   in   ADDR_WIDTH  write address
//  req_wdata  in   DATA_WIDTH  write data
//  rsp_valid  out  1           operands valid (read requests only)
//  rsp_ready  in   1           consumer takes response
//  rsp_op1    out  DATA_WIDTH  operand 1
//  rsp_op2    out  DATA_WIDTH  operand 2
//  rf_read    out  1           to register file READ
//  rf_write   out  1           to register file WRITE
//  rf_addr_r1 out  ADDR_WIDTH  to ADDR_R1
//  rf_addr_r2 out  ADDR_WIDTH  to ADDR_R2
//  rf_addr_w  out  ADDR_WIDTH  to ADDR_W
//  rf_data_w  out  DATA_WIDTH  to DATA_W
//  rf_data_r1 in   DATA_WIDTH  from DATA_R1; Z when READ=0, never used then
//  rf_data_r2 in   DATA_WIDTH  from DATA_R2
// BEHAVIOUR
//  Reset:
//   - state=IDLE; req_ready=1; rsp_valid=0; rf_read=rf_write=0.
//   - All address, data and operand outputs = 0.
//  FSM states: IDLE, READ, WRITE, RESP.
//  IDLE, on accept:
//   - Latch all req_* fields; req_ready drops the following cycle.
//   - rd=1: ->READ. rd=0, wr=1: ->WRITE. rd=0, wr=0: accept as a no-op, stay IDLE.
//  READ (1 cycle):
//   - rf_read=1; rf_addr_r1/r2 driven from latched rs1/rs2.
//   - rf_data_r1/r2 captured into rsp_op1/op2 at the closing edge.
//   - Next: WRITE if wr latched, else RESP.
//  WRITE (1 cycle):
//   - rf_write=1 with latched rd_a/wdata; the register file commits at the closing edge.
//   - Next: RESP if rd latched, else IDLE.
//  Ordering for rd&wr: read-before-write, so operands return the OLD value of rd_a.
//  RESP:
//   - rsp_valid=1; rsp_op1/op2 stable until rsp_valid&rsp_ready.
//   - On that cycle: ->IDLE, req_ready=1 next cycle.
//  Latency, accept edge to rsp_valid:
//   - 2 cycles for read-only.
//   - 3 cycles for read+write.
//   - Write-only: rf_write pulses 1 cycle after accept; back in IDLE 2 cycles after accept.
//  rf_read and rf_write are never 1 together.
//  Between transactions rf_read=rf_write=0 and addresses hold their last value.
//  RST mid-transaction: abort immediately, no strobe in the following cycle,
//  response dropped, outputs to reset values.
//  Widths: pure pass-through; no arithmetic.
// CONFIGURATION
//  RF_ZERO_REG_EN defined:
//   - Register 0 is hardwired zero.
//   - Operand whose address is 0 returns 0 regardless of rf_data_r*.
//   - Write with rd_a=0 suppresses rf_write (WRITE state still taken, strobe 0).
//  Undefined: register 0 is an ordinary register, read and written normally.
// STRUCTURE
//  Package rf_seq_pkg holds:
//   - state enum (IDLE/READ/WRITE/RESP);
//   - DATA_WIDTH/ADDR_WIDTH defaults;
//   - request struct {rd, wr, rs1, rs2, rd_a, wdata}.
//  No sub-module: FSM, request latch and response register are all in this module.
// TESTING (bench instantiates this block with the 32x32 register file)
//  1. Write-only, rd_a=5, wdata=32'hDEADBEEF:
//     one-cycle rf_write; no rsp_valid; req_ready=1 again 2 cycles after accept.
//  2. Read rs1=5, rs2=5 after test 1: rsp_op1=rsp_op2=32'hDEADBEEF, rsp_valid 2 cycles after accept.
//  3. rd&wr, rs1=rd_a=7, reg7=32'h1, wdata=32'h2:
//     rsp_op1=32'h1; a later read of 7 returns 32'h2.
//  4. Hold rsp_ready=0 for 4 cycles: rsp_valid and operands stable; req_ready stays 0.
//  5. RST=1 during READ: next cycle all outputs at reset values; no rf_write; no rsp_valid.
//  6. RF_ZERO_REG_EN on, write 32'hFF to reg 0 then read rs1=0:
//     rf_write stays 0; rsp_op1=0. Macro off: rsp_op1=32'hFF.

Source files
------------

// File: rtl/rf_seq_pkg.sv
// Shared types for the register-file access sequencer: FSM state encoding,
// default widths and the latched request record.
package rf_seq_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_t;

    typedef struct packed {
        logic                      rd;
        logic                      wr;
        logic [DEF_ADDR_WIDTH-1:0] rs1;
        logic [DEF_ADDR_WIDTH-1:0] rs2;
        logic [DEF_ADDR_WIDTH-1:0] rd_a;
        logic [DEF_DATA_WIDTH-1:0] wdata;
    } req_t;

endpackage

// File: rtl/rf_access_sequencer.sv
// Initiator for the dual-read register file: sequences READ then WRITE strobes per request
// and holds fetched operands on a response channel. Optional macro RF_ZERO_REG_EN hardwires register 0.
module rf_access_sequencer
    import rf_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_rd,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_rs1,
    input  logic [ADDR_WIDTH-1:0] req_rs2,
    input  logic [ADDR_WIDTH-1:0] req_rd_a,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_op1,
    output logic [DATA_WIDTH-1:0] rsp_op2,
    output logic                  rf_read,
    output logic                  rf_write,
    output logic [ADDR_WIDTH-1:0] rf_addr_r1,
    output logic [ADDR_WIDTH-1:0] rf_addr_r2,
    output logic [ADDR_WIDTH-1:0] rf_addr_w,
    output logic [DATA_WIDTH-1:0] rf_data_w,
    input  logic [DATA_WIDTH-1:0] rf_data_r1,
    input  logic [DATA_WIDTH-1:0] rf_data_r2
);

`ifdef RF_ZERO_REG_EN
    localparam bit ZERO_REG_EN = 1'b1;
`else
    localparam bit ZERO_REG_EN = 1'b0;
`endif

    state_t                state;
    req_t                  req_q;
    logic [DATA_WIDTH-1:0] op1_in;
    logic [DATA_WIDTH-1:0] op2_in;
    logic                  wr_ok_new;
    logic                  wr_ok_q;

    // Register 0 reads as zero and swallows writes when hardwired.
    always_comb begin
        op1_in    = rf_data_r1;
        op2_in    = rf_data_r2;
        wr_ok_new = 1'b1;
        wr_ok_q   = 1'b1;
        if (ZERO_REG_EN) begin
            if (req_q.rs1 == '0)  op1_in    = '0;
            if (req_q.rs2 == '0)  op2_in    = '0;
            if (req_rd_a == '0)   wr_ok_new = 1'b0;
            if (req_q.rd_a == '0) wr_ok_q   = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            req_q      <= '0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_op1    <= '0;
            rsp_op2    <= '0;
            rf_read    <= 1'b0;
            rf_write   <= 1'b0;
            rf_addr_r1 <= '0;
            rf_addr_r2 <= '0;
            rf_addr_w  <= '0;
            rf_data_w  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_q <= '{rd: req_rd, wr: req_wr, rs1: req_rs1, rs2: req_rs2,
                                   rd_a: req_rd_a, wdata: req_wdata};
                        // A no-op request leaves the register-file port untouched.
                        if (req_rd || req_wr) begin
                            rf_addr_r1 <= req_rs1;
                            rf_addr_r2 <= req_rs2;
                            rf_addr_w  <= req_rd_a;
                            rf_data_w  <= req_wdata;
                            req_ready  <= 1'b0;
                        end
                        if (req_rd) begin
                            state   <= READ;
                            rf_read <= 1'b1;
                        end else if (req_wr) begin
                            state    <= WRITE;
                            rf_write <= wr_ok_new;
                        end
                    end
                end
                READ: begin
                    rf_read <= 1'b0;
                    rsp_op1 <= op1_in;
                    rsp_op2 <= op2_in;
                    if (req_q.wr) begin
                        state    <= WRITE;
                        rf_write <= wr_ok_q;
                    end else begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                    end
                end
                WRITE: begin
                    rf_write <= 1'b0;
                    if (req_q.rd) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                    end else begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_access_sequencer.sv
// Directed bench for rf_access_sequencer with a behavioural 32x32 register file;
// expectations follow RF_ZERO_REG_EN when that macro is defined for the build.
module tb_rf_access_sequencer;

    logic        CLK, RST;
    logic        req_valid, req_ready, req_rd, req_wr;
    logic [4:0]  req_rs1, req_rs2, req_rd_a;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_op1, rsp_op2;
    logic        rf_read, rf_write;
    logic [4:0]  rf_addr_r1, rf_addr_r2, rf_addr_w;
    logic [31:0] rf_data_w, rf_data_r1, rf_data_r2;

    logic [31:0] regs [32];
    logic        overlap_seen;
    int          assertions;
    int          failures;

    rf_access_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd), .req_wr(req_wr),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd_a(req_rd_a), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op1(rsp_op1), .rsp_op2(rsp_op2),
        .rf_read(rf_read), .rf_write(rf_write),
        .rf_addr_r1(rf_addr_r1), .rf_addr_r2(rf_addr_r2), .rf_addr_w(rf_addr_w),
        .rf_data_w(rf_data_w), .rf_data_r1(rf_data_r1), .rf_data_r2(rf_data_r2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Register file: combinational read while READ is high, commit on the closing edge.
    assign rf_data_r1 = rf_read ? regs[rf_addr_r1] : 'z;
    assign rf_data_r2 = rf_read ? regs[rf_addr_r2] : 'z;
    always @(posedge CLK) begin
        if (rf_write) regs[rf_addr_w] <= rf_data_w;
        if (rf_read && rf_write) overlap_seen <= 1'b1;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_req(input logic rd, input logic wr, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [4:0] rd_a, input logic [31:0] wdata);
        req_valid = 1'b1; req_rd = rd; req_wr = wr;
        req_rs1 = rs1; req_rs2 = rs2; req_rd_a = rd_a; req_wdata = wdata;
        tick();
        req_valid = 1'b0; req_rd = 1'b0; req_wr = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick(); tick();
        assertions++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready: got %b expected 1", req_ready); end
        assertions++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
        assertions++; if ({rf_read, rf_write} !== 2'b00) begin failures++; $display("FAIL rst_strobes: got %b expected 00", {rf_read, rf_write}); end
        assertions++; if ({rf_addr_r1, rf_addr_r2, rf_addr_w} !== 15'h0) begin failures++; $display("FAIL rst_addrs: got %h expected 0", {rf_addr_r1, rf_addr_r2, rf_addr_w}); end
        assertions++; if ({rf_data_w, rsp_op1, rsp_op2} !== 96'h0) begin failures++; $display("FAIL rst_data: got %h expected 0", {rf_data_w, rsp_op1, rsp_op2}); end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_write_only();
        drive_req(1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 32'hDEADBEEF);
        assertions++; if (rf_write !== 1'b1) begin failures++; $display("FAIL wo_strobe: got %b expected 1", rf_write); end
        assertions++; if (rf_read !== 1'b0) begin failures++; $display("FAIL wo_no_read: got %b expected 0", rf_read); end
        assertions++; if (rf_addr_w !== 5'd5) begin failures++; $display("FAIL wo_addr: got %0d expected 5", rf_addr_w); end
        assertions++; if (rf_data_w !== 32'hDEADBEEF) begin failures++; $display("FAIL wo_data: got %h expected deadbeef", rf_data_w); end
        assertions++; if (req_ready !== 1'b0) begin failures++; $display("FAIL wo_busy: got %b expected 0", req_ready); end
        tick();
        assertions++; if (rf_write !== 1'b0) begin failures++; $display("FAIL wo_pulse_end: got %b expected 0", rf_write); end
        assertions++; if (req_ready !== 1'b1) begin failures++; $display("FAIL wo_ready_back: got %b expected 1", req_ready); end
        assertions++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL wo_no_rsp: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_read();
        drive_req(1'b1, 1'b0, 5'd5, 5'd5, 5'd9, 32'h0);
        assertions++; if (rf_read !== 1'b1) begin failures++; $display("FAIL rd_strobe: got %b expected 1", rf_read); end
        assertions++; if ({rf_addr_r1, rf_addr_r2} !== {5'd5, 5'd5}) begin failures++; $display("FAIL rd_addrs: got %h expected 0a5", {rf_addr_r1, rf_addr_r2}); end
        assertions++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rd_early_rsp: got %b expected 0", rsp_valid); end
        tick();
        assertions++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL rd_rsp_valid: got %b expected 1", rsp_valid); end
        assertions++; if (rsp_op1 !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_op1: got %h expected deadbeef", rsp_op1); end
        assertions++; if (rsp_op2 !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_op2: got %h expected deadbeef", rsp_op2); end
        assertions++; if ({rf_read, rf_write} !== 2'b00) begin failures++; $display("FAIL rd_resp_strobes: got %b expected 00", {rf_read, rf_write}); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        assertions++; if ({rsp_valid, req_ready} !== 2'b01) begin failures++; $display("FAIL rd_release: got %b expected 01", {rsp_valid, req_ready}); end
    endtask

    task automatic test_read_write();
        drive_req(1'b0, 1'b1, 5'd0, 5'd0, 5'd7, 32'h1);
        tick();
        drive_req(1'b1, 1'b1, 5'd7, 5'd5, 5'd7, 32'h2);
        assertions++; if ({rf_read, rf_write} !== 2'b10) begin failures++; $display("FAIL rw_read_first: got %b expected 10", {rf_read, rf_write}); end
        tick();
        assertions++; if ({rf_read, rf_write} !== 2'b01) begin failures++; $display("FAIL rw_write_second: got %b expected 01", {rf_read, rf_write}); end
        assertions++; if ({rf_addr_w, rf_data_w} !== {5'd7, 32'h2}) begin failures++; $display("FAIL rw_wport: got %h expected 700000002", {rf_addr_w, rf_data_w}); end
        assertions++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rw_early_rsp: got %b expected 0", rsp_valid); end
        tick();
        assertions++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL rw_rsp_valid: got %b expected 1", rsp_valid); end
        assertions++; if (rsp_op1 !== 32'h1) begin failures++; $display("FAIL rw_old_value: got %h expected 00000001", rsp_op1); end
        assertions++; if (rsp_op2 !== 32'hDEADBEEF) begin failures++; $display("FAIL rw_op2: got %h expected deadbeef", rsp_op2); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        drive_req(1'b1, 1'b0, 5'd7, 5'd7, 5'd0, 32'h0);
        tick();
        assertions++; if (rsp_op1 !== 32'h2) begin failures++; $display("FAIL rw_new_value: got %h expected 00000002", rsp_op1); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        drive_req(1'b1, 1'b0, 5'd5, 5'd7, 5'd0, 32'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            assertions++; if ({rsp_valid, req_ready} !== 2'b10) begin failures++; $display("FAIL bp_hold_%0d: got %b expected 10", i, {rsp_valid, req_ready}); end
            assertions++; if ({rsp_op1, rsp_op2} !== {32'hDEADBEEF, 32'h2}) begin failures++; $display("FAIL bp_ops_%0d: got %h expected deadbeef00000002", i, {rsp_op1, rsp_op2}); end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        assertions++; if ({rsp_valid, req_ready} !== 2'b01) begin failures++; $display("FAIL bp_release: got %b expected 01", {rsp_valid, req_ready}); end
    endtask

    task automatic test_noop();
        drive_req(1'b0, 1'b0, 5'd3, 5'd4, 5'd6, 32'h55);
        assertions++; if ({req_ready, rf_read, rf_write, rsp_valid} !== 4'b1000) begin failures++; $display("FAIL noop_idle: got %b expected 1000", {req_ready, rf_read, rf_write, rsp_valid}); end
        assertions++; if (rf_addr_r1 !== 5'd5) begin failures++; $display("FAIL noop_addr_hold: got %0d expected 5", rf_addr_r1); end
    endtask

    task automatic test_reset_mid();
        drive_req(1'b1, 1'b1, 5'd5, 5'd5, 5'd9, 32'h77);
        assertions++; if (rf_read !== 1'b1) begin failures++; $display("FAIL mid_in_read: got %b expected 1", rf_read); end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        assertions++; if ({req_ready, rsp_valid, rf_read, rf_write} !== 4'b1000) begin failures++; $display("FAIL mid_ctrl: got %b expected 1000", {req_ready, rsp_valid, rf_read, rf_write}); end
        assertions++; if ({rf_addr_r1, rf_addr_r2, rf_addr_w} !== 15'h0) begin failures++; $display("FAIL mid_addrs: got %h expected 0", {rf_addr_r1, rf_addr_r2, rf_addr_w}); end
        assertions++; if ({rf_data_w, rsp_op1, rsp_op2} !== 96'h0) begin failures++; $display("FAIL mid_data: got %h expected 0", {rf_data_w, rsp_op1, rsp_op2}); end
        tick();
        assertions++; if ({rsp_valid, rf_write} !== 2'b00) begin failures++; $display("FAIL mid_after: got %b expected 00", {rsp_valid, rf_write}); end
        assertions++; if (regs[9] !== 32'h0) begin failures++; $display("FAIL mid_no_commit: got %h expected 0", regs[9]); end
    endtask

    task automatic test_zero_reg();
        logic        exp_wr;
        logic [31:0] exp_op1;
`ifdef RF_ZERO_REG_EN
        exp_wr = 1'b0; exp_op1 = 32'h0;
`else
        exp_wr = 1'b1; exp_op1 = 32'hFF;
`endif
        drive_req(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'hFF);
        assertions++; if (rf_write !== exp_wr) begin failures++; $display("FAIL zr_write: got %b expected %b", rf_write, exp_wr); end
        tick();
        drive_req(1'b1, 1'b0, 5'd0, 5'd5, 5'd0, 32'h0);
        tick();
        assertions++; if (rsp_op1 !== exp_op1) begin failures++; $display("FAIL zr_op1: got %h expected %h", rsp_op1, exp_op1); end
        assertions++; if (rsp_op2 !== 32'hDEADBEEF) begin failures++; $display("FAIL zr_op2: got %h expected deadbeef", rsp_op2); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_exclusive();
        assertions++; if (overlap_seen !== 1'b0) begin failures++; $display("FAIL strobe_overlap: got %b expected 0", overlap_seen); end
    endtask

    initial begin
        assertions = 0; failures = 0; overlap_seen = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        RST = 1'b1; req_valid = 1'b0; req_rd = 1'b0; req_wr = 1'b0;
        req_rs1 = '0; req_rs2 = '0; req_rd_a = '0; req_wdata = '0; rsp_ready = 1'b0;
        test_reset();
        test_write_only();
        test_read();
        test_read_write();
        test_backpressure();
        test_noop();
        test_reset_mid();
        test_zero_reg();
        test_exclusive();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
